// File: rtl/hpm_pkg.sv
// Shared types and constants for the hardware performance-monitor counter bank.
package hpm_pkg;

  typedef enum logic [1:0] {
    FLD_COUNT = 2'd0,
    FLD_EVSEL = 2'd1,
    FLD_CTRL  = 2'd2,
    FLD_OVF   = 2'd3
  } reg_field_e;

  // Code 2 is taken by retire, so event k is selected by SRC_EVT_BASE + k.
  localparam int SRC_OFF      = 0;
  localparam int SRC_CYCLE    = 1;
  localparam int SRC_RETIRE   = 2;
  localparam int SRC_EVT_BASE = 3;

  typedef struct packed {
    logic freeze_on_ovf;
    logic ovf_ie;
    logic inhibit;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic int evsel_width(input int num_evt);
    return $clog2(num_evt + SRC_EVT_BASE);
  endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// Register port, event inputs and status outputs of the counter bank.
interface hpm_counter_bank_if #(
  parameter int WIDTH    = 64,
  parameter int NUM_CNT  = 4,
  parameter int NUM_EVT  = 8,
  parameter int RETIRE_W = 2
);
  localparam int IDX_W = $clog2(NUM_CNT);

  logic                cycle_en;
  logic [RETIRE_W-1:0] retire_cnt;
  logic [NUM_EVT-1:0]  evt_i;
  logic                reg_wr;
  logic                reg_rd;
  logic [IDX_W-1:0]    reg_idx;
  logic [1:0]          reg_field;
  logic [WIDTH-1:0]    reg_wdata;
  logic [WIDTH-1:0]    reg_rdata;
  logic                rd_valid;
  logic [NUM_CNT-1:0]  ovf_o;
  logic                irq_o;

  modport master (
    output cycle_en, retire_cnt, evt_i, reg_wr, reg_rd, reg_idx, reg_field, reg_wdata,
    input  reg_rdata, rd_valid, ovf_o, irq_o
  );

  modport slave (
    input  cycle_en, retire_cnt, evt_i, reg_wr, reg_rd, reg_idx, reg_field, reg_wdata,
    output reg_rdata, rd_valid, ovf_o, irq_o
  );

endinterface

// File: rtl/hpm_counter_slice.sv
// One performance counter: source select, increment, control bits and sticky overflow.
module hpm_counter_slice
  import hpm_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NUM_EVT   = 8,
  parameter int RETIRE_W  = 2,
  parameter int EVSEL_W   = 4,
  parameter int EVSEL_RST = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                count_en,
  input  logic [RETIRE_W-1:0] retire_cnt,
  input  logic [NUM_EVT-1:0]  evt,
  input  logic                wr_count,
  input  logic                wr_evsel,
  input  logic                wr_ctrl,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                ovf_clr,
  output logic [WIDTH-1:0]    count,
  output logic [EVSEL_W-1:0]  evsel,
  output ctrl_t               ctrl,
  output logic                ovf,
  output logic                ovf_set
);

  logic [WIDTH-1:0] inc;
  logic [WIDTH:0]   sum;
  logic             active;

  always_comb begin
    inc = '0;
    if (evsel == EVSEL_W'(SRC_CYCLE)) begin
      inc = WIDTH'(1);
    end else if (evsel == EVSEL_W'(SRC_RETIRE)) begin
      inc = WIDTH'(retire_cnt);
    end else begin
      for (int k = 0; k < NUM_EVT; k++) begin
        if (evsel == EVSEL_W'(SRC_EVT_BASE + k)) inc = WIDTH'(evt[k]);
      end
    end
  end

  // A register write to the count drops this cycle's increment and its carry.
  assign active  = count_en & ~ctrl.inhibit & ~wr_count;
  assign sum     = {1'b0, count} + {1'b0, inc};
  assign ovf_set = active & sum[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      evsel <= EVSEL_W'(EVSEL_RST);
      ctrl  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_count)    count <= wdata;
      else if (active) count <= sum[WIDTH-1:0];
      if (wr_evsel) evsel <= wdata[EVSEL_W-1:0];
      if (wr_ctrl)  ctrl  <= ctrl_t'(wdata[CTRL_W-1:0]);
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// Performance counter bank: register decode, global freeze, read port and overflow interrupt.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NUM_CNT  = 4,
  parameter int NUM_EVT  = 8,
  parameter int RETIRE_W = 2
) (
  input logic               clk,
  input logic               rst,
  hpm_counter_bank_if.slave bus
);

  localparam int IDX_W   = $clog2(NUM_CNT);
  localparam int EVSEL_W = evsel_width(NUM_EVT);

  logic [WIDTH-1:0]   count [NUM_CNT];
  logic [EVSEL_W-1:0] evsel [NUM_CNT];
  ctrl_t              ctrl  [NUM_CNT];
  logic [NUM_CNT-1:0] ovf, ovf_set, ovf_ie, freeze_hit;
  logic [NUM_CNT-1:0] wr_count, wr_evsel, wr_ctrl, ovf_clr;
  logic               frozen, count_en;
  reg_field_e         field;
  logic [WIDTH-1:0]   rd_mux;
  logic [WIDTH-1:0]   rdata_p1;
  logic               vld_p1;

  assign field    = reg_field_e'(bus.reg_field);
  assign count_en = bus.cycle_en & ~frozen;

  // Out-of-range indices match no slice, so their writes vanish and reads return zero.
  always_comb begin
    wr_count = '0;
    wr_evsel = '0;
    wr_ctrl  = '0;
    ovf_clr  = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (bus.reg_wr && bus.reg_idx == IDX_W'(i)) begin
        wr_count[i] = (field == FLD_COUNT);
        wr_evsel[i] = (field == FLD_EVSEL);
        wr_ctrl[i]  = (field == FLD_CTRL);
      end
      ovf_clr[i] = bus.reg_wr && (field == FLD_OVF) && bus.reg_wdata[i];
    end
  end

  always_comb begin
    ovf_ie     = '0;
    freeze_hit = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      ovf_ie[i]     = ctrl[i].ovf_ie;
      freeze_hit[i] = ovf_set[i] & ctrl[i].freeze_on_ovf;
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    hpm_counter_slice #(
      .WIDTH    (WIDTH),
      .NUM_EVT  (NUM_EVT),
      .RETIRE_W (RETIRE_W),
      .EVSEL_W  (EVSEL_W),
      .EVSEL_RST(i == 0 ? SRC_CYCLE : (i == 1 ? SRC_RETIRE : SRC_OFF))
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .count_en  (count_en),
      .retire_cnt(bus.retire_cnt),
      .evt       (bus.evt_i),
      .wr_count  (wr_count[i]),
      .wr_evsel  (wr_evsel[i]),
      .wr_ctrl   (wr_ctrl[i]),
      .wdata     (bus.reg_wdata),
      .ovf_clr   (ovf_clr[i]),
      .count     (count[i]),
      .evsel     (evsel[i]),
      .ctrl      (ctrl[i]),
      .ovf       (ovf[i]),
      .ovf_set   (ovf_set[i])
    );
  end

  // Frozen drops only after a full cycle with no overflow flag standing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 frozen <= 1'b0;
    else if (|freeze_hit)    frozen <= 1'b1;
    else if (ovf == '0)      frozen <= 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    if (field == FLD_OVF) begin
      rd_mux = WIDTH'(ovf);
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (bus.reg_idx == IDX_W'(i)) begin
          case (field)
            FLD_COUNT: rd_mux = count[i];
            FLD_EVSEL: rd_mux = WIDTH'(evsel[i]);
            FLD_CTRL:  rd_mux = WIDTH'({ctrl[i]});
            default:   rd_mux = '0;
          endcase
        end
      end
    end
  end

  // p1: registered read response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= bus.reg_rd;
      if (bus.reg_rd) rdata_p1 <= rd_mux;
    end
  end

  assign bus.reg_rdata = rdata_p1;
  assign bus.rd_valid  = vld_p1;
  assign bus.ovf_o     = ovf;
  assign bus.irq_o     = |(ovf & ovf_ie);

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank: reads are scored against a queue of expected values.
module tb_hpm_counter_bank;
  import hpm_pkg::*;

  localparam int WIDTH    = 64;
  localparam int NUM_CNT  = 3;
  localparam int NUM_EVT  = 8;
  localparam int RETIRE_W = 2;
  localparam int IDX_W    = $clog2(NUM_CNT);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hpm_counter_bank_if #(.WIDTH(WIDTH), .NUM_CNT(NUM_CNT), .NUM_EVT(NUM_EVT), .RETIRE_W(RETIRE_W)) bus ();

  hpm_counter_bank #(.WIDTH(WIDTH), .NUM_CNT(NUM_CNT), .NUM_EVT(NUM_EVT), .RETIRE_W(RETIRE_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [WIDTH-1:0] exp_q[$];
  string            name_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic rd(input int idx, input reg_field_e f, input logic [WIDTH-1:0] exp, input string nm);
    bus.reg_rd    = 1'b1;
    bus.reg_idx   = IDX_W'(idx);
    bus.reg_field = f;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    step(1);
    bus.reg_rd = 1'b0;
  endtask

  task automatic wr(input int idx, input reg_field_e f, input logic [WIDTH-1:0] d);
    bus.reg_wr    = 1'b1;
    bus.reg_idx   = IDX_W'(idx);
    bus.reg_field = f;
    bus.reg_wdata = d;
    step(1);
    bus.reg_wr = 1'b0;
  endtask

  task automatic monitor();
    logic [WIDTH-1:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: got rd_valid=1 rdata=%0h, required no response", bus.reg_rdata);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (bus.reg_rdata !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, bus.reg_rdata, e);
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    #1 rst = 1'b1;
    step(2);
    chk("rst_rd_valid", WIDTH'(bus.rd_valid), 64'd0);
    chk("rst_rdata", bus.reg_rdata, 64'd0);
    chk("rst_ovf", WIDTH'(bus.ovf_o), 64'd0);
    chk("rst_irq", WIDTH'(bus.irq_o), 64'd0);
    rst = 1'b0;

    // cycle counter runs for exactly ten edges
    step(10);
    bus.cycle_en = 1'b0;
    rd(0, FLD_COUNT, 64'd10, "t1_cnt0");
    rd(1, FLD_COUNT, 64'd0,  "t1_cnt1");
    rd(2, FLD_COUNT, 64'd0,  "t1_cnt2");
    rd(0, FLD_EVSEL, 64'd1,  "t1_evsel0");
    rd(1, FLD_EVSEL, 64'd2,  "t1_evsel1");
    rd(2, FLD_EVSEL, 64'd0,  "t1_evsel2");
    rd(0, FLD_CTRL,  64'd0,  "t1_ctrl0");
    chk("t1_irq", WIDTH'(bus.irq_o), 64'd0);

    // multi-retire and inhibit
    bus.cycle_en = 1'b1; bus.retire_cnt = 2'd3;
    step(4);
    bus.cycle_en = 1'b0; bus.retire_cnt = 2'd0;
    rd(1, FLD_COUNT, 64'd12, "t2_cnt1");
    rd(0, FLD_COUNT, 64'd14, "t2_cnt0");
    wr(1, FLD_CTRL, 64'd1);
    bus.cycle_en = 1'b1; bus.retire_cnt = 2'd3;
    step(4);
    bus.cycle_en = 1'b0; bus.retire_cnt = 2'd0;
    rd(1, FLD_COUNT, 64'd12, "t2_cnt1_inhibited");
    rd(0, FLD_COUNT, 64'd18, "t2_cnt0");
    rd(1, FLD_CTRL,  64'd1,  "t2_ctrl1");

    // event-driven wrap with interrupt
    wr(2, FLD_COUNT, ONES - 64'd1);
    wr(2, FLD_EVSEL, 64'd3);
    wr(2, FLD_CTRL,  64'd2);
    bus.cycle_en = 1'b1; bus.evt_i = 8'd1;
    step(1);
    bus.evt_i = 8'd0;
    step(1);
    chk("t3_irq_before_wrap", WIDTH'(bus.irq_o), 64'd0);
    bus.evt_i = 8'd1;
    step(1);
    bus.evt_i = 8'd0; bus.cycle_en = 1'b0;
    chk("t3_irq", WIDTH'(bus.irq_o), 64'd1);
    chk("t3_ovf_o", WIDTH'(bus.ovf_o), 64'd4);
    rd(2, FLD_COUNT, 64'd0,  "t3_cnt2_wrapped");
    rd(0, FLD_OVF,   64'd4,  "t3_ovf_field");
    rd(0, FLD_COUNT, 64'd21, "t3_cnt0");
    wr(0, FLD_OVF, 64'd4);
    chk("t3_ovf_cleared", WIDTH'(bus.ovf_o), 64'd0);
    chk("t3_irq_cleared", WIDTH'(bus.irq_o), 64'd0);

    // all-ones + 3 wraps to 2; no interrupt without ovf_ie
    wr(1, FLD_CTRL,  64'd0);
    wr(1, FLD_COUNT, ONES);
    bus.cycle_en = 1'b1; bus.retire_cnt = 2'd3;
    step(1);
    bus.cycle_en = 1'b0; bus.retire_cnt = 2'd0;
    chk("t3_ovf1", WIDTH'(bus.ovf_o), 64'd2);
    chk("t3_irq_masked", WIDTH'(bus.irq_o), 64'd0);
    rd(1, FLD_COUNT, 64'd2,  "t3_cnt1_wrap3");
    rd(0, FLD_COUNT, 64'd22, "t3_cnt0_b");
    wr(0, FLD_OVF, 64'd2);
    chk("t3_ovf1_cleared", WIDTH'(bus.ovf_o), 64'd0);

    // freeze on overflow, resume one cycle after the clear
    wr(2, FLD_CTRL,  64'd6);
    wr(2, FLD_COUNT, ONES);
    bus.cycle_en = 1'b1; bus.evt_i = 8'd1;
    step(1);
    bus.evt_i = 8'd0; bus.retire_cnt = 2'd3;
    step(3);
    rd(0, FLD_COUNT, 64'd23, "t4_cnt0_frozen");
    rd(1, FLD_COUNT, 64'd2,  "t4_cnt1_frozen");
    chk("t4_irq", WIDTH'(bus.irq_o), 64'd1);
    wr(0, FLD_OVF, 64'd4);
    chk("t4_ovf_cleared", WIDTH'(bus.ovf_o), 64'd0);
    step(2);
    bus.cycle_en = 1'b0; bus.retire_cnt = 2'd0;
    rd(0, FLD_COUNT, 64'd24, "t4_cnt0_resumed");
    rd(1, FLD_COUNT, 64'd5,  "t4_cnt1_resumed");
    wr(2, FLD_CTRL, 64'd2);

    // write beats increment; hardware set beats W1C
    bus.cycle_en = 1'b1; bus.evt_i = 8'd1;
    wr(2, FLD_COUNT, 64'd100);
    bus.cycle_en = 1'b0; bus.evt_i = 8'd0;
    rd(2, FLD_COUNT, 64'd100, "t5_cnt2_write_wins");
    rd(0, FLD_OVF,   64'd0,   "t5_no_ovf");
    rd(0, FLD_COUNT, 64'd25,  "t5_cnt0");
    wr(2, FLD_COUNT, ONES);
    bus.cycle_en = 1'b1; bus.evt_i = 8'd1;
    wr(0, FLD_OVF, 64'd4);
    bus.cycle_en = 1'b0; bus.evt_i = 8'd0;
    chk("t5_ovf_set_wins", WIDTH'(bus.ovf_o), 64'd4);
    chk("t5_irq", WIDTH'(bus.irq_o), 64'd1);
    rd(2, FLD_COUNT, 64'd0,  "t5_cnt2_wrapped");
    rd(0, FLD_COUNT, 64'd26, "t5_cnt0");
    wr(0, FLD_OVF, 64'd7);
    chk("t5_ovf_cleared", WIDTH'(bus.ovf_o), 64'd0);

    // out-of-range index, simultaneous read/write, rdata hold
    rd(3, FLD_COUNT, 64'd0, "t6_oob_count");
    rd(3, FLD_CTRL,  64'd0, "t6_oob_ctrl");
    wr(3, FLD_COUNT, 64'd55);
    rd(0, FLD_COUNT, 64'd26, "t6_cnt0_untouched");
    rd(1, FLD_COUNT, 64'd5,  "t6_cnt1_untouched");
    rd(2, FLD_COUNT, 64'd0,  "t6_cnt2_untouched");
    bus.reg_wr = 1'b1; bus.reg_wdata = 64'd7;
    rd(2, FLD_COUNT, 64'd0, "t6_rdwr_old_value");
    bus.reg_wr = 1'b0;
    rd(2, FLD_COUNT, 64'd7, "t6_rdwr_new_value");
    step(3);
    chk("t6_rdata_hold", bus.reg_rdata, 64'd7);
    chk("t6_rd_valid_idle", WIDTH'(bus.rd_valid), 64'd0);

    // asynchronous reset mid-count with a read in flight
    wr(2, FLD_COUNT, ONES);
    bus.cycle_en = 1'b1; bus.evt_i = 8'd1;
    step(1);
    bus.evt_i = 8'd0;
    step(2);
    chk("t6_irq_before_rst", WIDTH'(bus.irq_o), 64'd1);
    bus.reg_rd = 1'b1; bus.reg_idx = '0; bus.reg_field = FLD_COUNT;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_rd_valid", WIDTH'(bus.rd_valid), 64'd0);
    chk("t6_rst_rdata", bus.reg_rdata, 64'd0);
    chk("t6_rst_ovf", WIDTH'(bus.ovf_o), 64'd0);
    chk("t6_rst_irq", WIDTH'(bus.irq_o), 64'd0);
    bus.reg_rd = 1'b0; bus.cycle_en = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    rd(0, FLD_COUNT, 64'd0, "t6_cnt0_after_rst");
    rd(2, FLD_EVSEL, 64'd0, "t6_evsel2_after_rst");
    rd(2, FLD_CTRL,  64'd0, "t6_ctrl2_after_rst");
    rd(1, FLD_EVSEL, 64'd2, "t6_evsel1_after_rst");
    step(3);
  endtask

  initial begin
    bus.cycle_en   = 1'b1;
    bus.retire_cnt = '0;
    bus.evt_i      = '0;
    bus.reg_wr     = 1'b0;
    bus.reg_rd     = 1'b0;
    bus.reg_idx    = '0;
    bus.reg_field  = '0;
    bus.reg_wdata  = '0;
    fork
      monitor();
      stimulus();
    join_any
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_missing: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
